aes_enc_cbc_stream: RTL and testbench

Streaming AES-128 CBC encryption engine; the transmit-side counterpart of the CBC decrypt path. It accepts plaintext blocks over a valid/ready input and XORs each with the chaining value: the IV for the first block, otherwise the previous ciphertext. It encrypts the result through one instance of the combinational `aes_encr` core and returns ciphertext over a valid/ready output. The block owns the chaining register, so upstream logic only supplies blocks and a first-block flag.

---
 rtl/aes_enc_cbc_stream.sv | 218 +++++++++++++++++++++
 tb/tb_aes_enc_cbc_stream.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_cbc_stream.sv
// Streaming AES-128 CBC encryptor wrapped around a combinational aes_encr core.
// Define AES_ENC_CBC_CNT_EN to add the blk_cnt output-block counter.

module aes_encr (
  input  logic         rst,
  input  logic [127:0] key,
  input  logic [127:0] data_in,
  output logic [127:0] data_out
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as the field inverse (x^254) followed by the affine map,
  // so no 256-entry table has to be maintained by hand.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] b;
    sq = x;
    b  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      b  = gf_mul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte 0 of the state sits in bits [127:120]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])} ^ {rc, 24'h0};
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64] ^ w0;
    w2 = prev[63:32] ^ w1;
    w3 = prev[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [127:0] rk;
  logic [127:0] st;
  logic [7:0]   rc;

  always_comb begin
    rk = key;
    rc = 8'h01;
    st = data_in ^ key;
    for (int r = 1; r <= 10; r++) begin
      rk = key_step(rk, rc);
      rc = xtime(rc);
      st = shift_rows(sub_bytes(st));
      if (r != 10) st = mix_columns(st);
      st = st ^ rk;
    end
    data_out = rst ? 128'h0 : st;
  end

endmodule

module aes_enc_cbc_stream #(
  parameter int CORE_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic         s_first,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         m_last,
  output logic         busy
`ifdef AES_ENC_CBC_CNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_OUT} state_t;

  state_t       state_reg;
  logic [127:0] chain_reg;
  logic [127:0] core_in_reg;
  logic [127:0] key_reg;
  logic         last_reg;
  logic [3:0]   lat_cnt_reg;
  logic [127:0] core_out;

  // The core sees only registered operands, so CORE_LAT-1 extra CALC cycles
  // give a multicycle path through the combinational rounds.
  aes_encr u_core (
    .rst      (1'b0),
    .key      (key_reg),
    .data_in  (core_in_reg),
    .data_out (core_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      s_ready     <= 1'b1;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      busy        <= 1'b0;
      chain_reg   <= '0;
      core_in_reg <= '0;
      key_reg     <= '0;
      last_reg    <= 1'b0;
      lat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (s_valid) begin
            core_in_reg <= s_data ^ (s_first ? iv : chain_reg);
            key_reg     <= key;
            last_reg    <= s_last;
            lat_cnt_reg <= 4'(CORE_LAT - 1);
            s_ready     <= 1'b0;
            busy        <= 1'b1;
            state_reg   <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (lat_cnt_reg == 4'd0) begin
            m_data    <= core_out;
            chain_reg <= core_out;
            m_last    <= last_reg;
            m_valid   <= 1'b1;
            state_reg <= ST_OUT;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 4'd1;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid   <= 1'b0;
            s_ready   <= 1'b1;
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          s_ready   <= 1'b1;
          m_valid   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef AES_ENC_CBC_CNT_EN
  // Accepts only happen in IDLE and output handshakes only in OUT, so the
  // clear and increment branches never compete.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_cnt <= '0;
    end else if (state_reg == ST_IDLE && s_valid && s_first) begin
      blk_cnt <= '0;
    end else if (m_valid && m_ready) begin
      blk_cnt <= blk_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_enc_cbc_stream.sv
// Directed bench for aes_enc_cbc_stream using FIPS-197 and SP800-38A vectors;
// one instance at CORE_LAT=1 and one at CORE_LAT=4.

module tb_aes_enc_cbc_stream;

  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P2   = 128'h69d5c2eb2e2e624750541d3bbc692ba5;
  localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] EP   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] EC   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  logic [127:0] cbc_pt [4] = '{128'h6bc1bee22e409f96e93d7e117393172a,
                               128'hae2d8a571e03ac9c9eb76fac45af8e51,
                               128'h30c81c46a35ce411e5fbc1191a0a52ef,
                               128'hf69f2445df4f9b17ad2b417be66c3710};
  logic [127:0] cbc_ct [4] = '{128'h7649abac8119b246cee98e9b12e9197d,
                               128'h5086cb9b507219ee95db113a917678b2,
                               128'h73bed6b8e3c1743b7116e69e22229516,
                               128'h3ff1caa1681fac09120eca307586e1a7};

  logic         clk, rst_n;
  logic [127:0] key, iv, s_data, m_data;
  logic         s_valid, s_ready, s_first, s_last, m_valid, m_ready, m_last, busy;
  logic [127:0] l4_key, l4_iv, l4_s_data, l4_m_data;
  logic         l4_s_valid, l4_s_ready, l4_s_first, l4_s_last;
  logic         l4_m_valid, l4_m_ready, l4_m_last, l4_busy;
`ifdef AES_ENC_CBC_CNT_EN
  logic [31:0]  blk_cnt, l4_blk_cnt;
`endif

  int n_cmp, n_err;

  aes_enc_cbc_stream #(.CORE_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .key(key), .iv(iv),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_first(s_first), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
`ifdef AES_ENC_CBC_CNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  aes_enc_cbc_stream #(.CORE_LAT(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n), .key(l4_key), .iv(l4_iv),
    .s_valid(l4_s_valid), .s_ready(l4_s_ready), .s_data(l4_s_data), .s_first(l4_s_first),
    .s_last(l4_s_last), .m_valid(l4_m_valid), .m_ready(l4_m_ready), .m_data(l4_m_data),
    .m_last(l4_m_last), .busy(l4_busy)
`ifdef AES_ENC_CBC_CNT_EN
    , .blk_cnt(l4_blk_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the input handshake.
  task automatic push(input logic [127:0] d, input logic f, input logic l);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_first = f;
    s_last  = l;
    n = 0;
    while (!s_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk1("in_ready", s_ready, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // lat counts cycles from the handshake cycle to the first m_valid cycle.
  task automatic pull(output logic [127:0] d, output logic l, output int lat);
    lat = 1;
    while (!m_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk1("out_valid", m_valid, 1'b1);
    d = m_data;
    l = m_last;
    if (m_ready) @(negedge clk);
  endtask

  logic [127:0] d;
  logic         l;
  int           lat, nacc, nmv, mv_first;
  int           acc [4];

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    key = '0; iv = '0; s_data = '0; s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    l4_key = '0; l4_iv = '0; l4_s_data = '0; l4_s_valid = 1'b0; l4_s_first = 1'b0;
    l4_s_last = 1'b0; l4_m_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk1("rst_s_ready", s_ready, 1'b1);
    chk1("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 128'h0);
    chk1("rst_m_last", m_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_l4_s_ready", l4_s_ready, 1'b1);
`ifdef AES_ENC_CBC_CNT_EN
    chki("rst_blk_cnt", int'(blk_cnt), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 single block
    key = K1; iv = '0; m_ready = 1'b1;
    push(P1, 1'b1, 1'b1);
    chk1("calc_busy", busy, 1'b1);
    chk1("calc_s_ready", s_ready, 1'b0);
    pull(d, l, lat);
    chk("fips_data", d, C1);
    chk1("fips_last", l, 1'b1);
    chki("fips_latency", lat, 2);
    chk1("post_s_ready", s_ready, 1'b1);
    chk1("post_m_valid", m_valid, 1'b0);
    chk1("post_busy", busy, 1'b0);

    // Chained block: P2 ^ C1 == P1
    push(P2, 1'b0, 1'b0);
    pull(d, l, lat);
    chk("chain_data", d, C1);
    chk1("chain_last", l, 1'b0);
    chki("chain_latency", lat, 2);
`ifdef AES_ENC_CBC_CNT_EN
    chki("chain_blk_cnt", int'(blk_cnt), 2);
`endif

    // New chain restarts from iv
    iv = '0;
    push(P1, 1'b1, 1'b0);
    pull(d, l, lat);
    chk("newchain_data", d, C1);
`ifdef AES_ENC_CBC_CNT_EN
    chki("newchain_blk_cnt", int'(blk_cnt), 1);
`endif

    // SP800-38A CBC, backpressure with key/iv/s_valid churn on block 2
    key = K2; iv = IV2;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) m_ready = 1'b0;
      push(cbc_pt[i], i == 0, i == 3);
      pull(d, l, lat);
      chk($sformatf("cbc%0d_data", i), d, cbc_ct[i]);
      chk1($sformatf("cbc%0d_last", i), l, i == 3);
      chki($sformatf("cbc%0d_latency", i), lat, 2);
      if (i == 2) begin
        for (int c = 0; c < 10; c++) begin
          s_valid = ~s_valid;
          key = ~key;
          iv = ~iv;
          @(negedge clk);
          chk("bp_m_data", m_data, cbc_ct[2]);
          chk1("bp_s_ready", s_ready, 1'b0);
        end
        s_valid = 1'b0; key = K2; iv = IV2;
        m_ready = 1'b1;
        @(negedge clk);
        chk1("bp_release_m_valid", m_valid, 1'b0);
        chk1("bp_release_s_ready", s_ready, 1'b1);
      end
    end
`ifdef AES_ENC_CBC_CNT_EN
    chki("cbc_blk_cnt", int'(blk_cnt), 4);
`endif

    // Reset during CALC: aborted block must never appear, chain restarts at 0
    key = K1;
    push(P1, 1'b1, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk1("abort_m_valid", m_valid, 1'b0);
      chk1("abort_s_ready", s_ready, 1'b1);
      @(negedge clk);
    end
    push(P1, 1'b0, 1'b1);
    pull(d, l, lat);
    chk("after_rst_data", d, C1);
    chki("after_rst_latency", lat, 2);
`ifdef AES_ENC_CBC_CNT_EN
    chki("after_rst_blk_cnt", int'(blk_cnt), 1);
`endif

    // Single block under a different key (ECB-equivalent: iv 0, first)
    key = K2; iv = '0;
    push(EP, 1'b1, 1'b0);
    pull(d, l, lat);
    chk("ecb_data", d, EC);

    // CORE_LAT=4: back-to-back accepts, junk key while the block is in flight
    l4_iv = '0; l4_s_data = P1; l4_s_first = 1'b1; l4_s_last = 1'b1;
    l4_m_ready = 1'b1; l4_s_valid = 1'b1;
    nacc = 0; nmv = 0; mv_first = -1;
    for (int k = 0; k < 4; k++) acc[k] = -1;
    for (int c = 0; c < 20; c++) begin
      l4_key = (c % 6 >= 1 && c % 6 <= 4) ? ~K1 : K1;
      if (l4_s_ready && nacc < 4) begin
        acc[nacc] = c;
        nacc++;
      end
      if (l4_m_valid) begin
        nmv++;
        chk("l4_data", l4_m_data, C1);
        chk1("l4_last", l4_m_last, 1'b1);
        if (mv_first < 0) mv_first = c;
      end
      if (c == 2) chk1("l4_busy", l4_busy, 1'b1);
      @(negedge clk);
    end
    l4_s_valid = 1'b0;
    chki("l4_accept0", acc[0], 0);
    chki("l4_accept1", acc[1], 6);
    chki("l4_accept2", acc[2], 12);
    chki("l4_first_valid", mv_first, 5);
    chki("l4_valid_count", nmv, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
